// File: rtl/psum_mem_arbiter.sv
// psum_mem_arbiter: shares the psum BRAM read and write controller channels
// between the core accumulate path (requester 0) and the drain engine
// (requester 1). Core has priority; a per-channel wait counter forces a drain
// grant after MAX_WAIT consecutive denials. An in-order tag FIFO steers each
// read return to the requester that issued it.
// Optional build macro PSUM_ARB_STAT_EN adds per-channel conflict counters.
module psum_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 8,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] c_radd,
   input  logic                  c_rden,
   output logic                  c_rstall,
   output logic [DATA_WIDTH-1:0] c_odat,
   output logic                  c_oval,
   input  logic [ADDR_WIDTH-1:0] c_wadd,
   input  logic                  c_wren,
   input  logic [DATA_WIDTH-1:0] c_idat,
   output logic                  c_wstall,
   input  logic [ADDR_WIDTH-1:0] d_radd,
   input  logic                  d_rden,
   output logic                  d_rstall,
   output logic [DATA_WIDTH-1:0] d_odat,
   output logic                  d_oval,
   input  logic [ADDR_WIDTH-1:0] d_wadd,
   input  logic                  d_wren,
   input  logic [DATA_WIDTH-1:0] d_idat,
   output logic                  d_wstall,
   output logic [ADDR_WIDTH-1:0] m_radd,
   output logic                  m_rden,
   input  logic [DATA_WIDTH-1:0] m_odat,
   input  logic                  m_oval,
   output logic [ADDR_WIDTH-1:0] m_wadd,
   output logic                  m_wren,
   output logic [DATA_WIDTH-1:0] m_idat,
   output logic                  o_err_orphan
`ifdef PSUM_ARB_STAT_EN
   ,
   output logic [31:0]           o_stat_rconf,
   output logic [31:0]           o_stat_wconf
`endif
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int PTR_W  = $clog2(TAG_DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(TAG_DEPTH);

   logic [WAIT_W-1:0]    rwait_q, rwait_d, wwait_q, wwait_d;
   logic [TAG_DEPTH-1:0] tag_q;
   logic [PTR_W-1:0]     wptr_q, rptr_q;
   logic [PTR_W:0]       cnt_q, cnt_d;
   logic                 c_oval_q, d_oval_q, err_q;
   logic [DATA_WIDTH-1:0] c_odat_q, d_odat_q;

   logic tag_full_s, tag_empty_s, head_s, push_s, pop_s;
   logic r_force_s, w_force_s;
   logic rgnt_c_s, rgnt_d_s, wgnt_c_s, wgnt_d_s;

   // A full tag FIFO blocks every read grant: no slot for the return route.
   assign tag_full_s  = (cnt_q == CNT_FULL);
   assign tag_empty_s = (cnt_q == '0);
   assign head_s      = tag_q[rptr_q];
   assign r_force_s   = (rwait_q == WAIT_MAX);
   assign w_force_s   = (wwait_q == WAIT_MAX);

   assign rgnt_d_s = d_rden & (~c_rden | r_force_s) & ~tag_full_s;
   assign rgnt_c_s = c_rden & ~(d_rden & r_force_s) & ~tag_full_s;
   assign wgnt_d_s = d_wren & (~c_wren | w_force_s);
   assign wgnt_c_s = c_wren & ~(d_wren & w_force_s);

   assign push_s = rgnt_c_s | rgnt_d_s;
   assign pop_s  = m_oval & ~tag_empty_s;

   assign c_rstall = tag_full_s | (c_rden & ~rgnt_c_s);
   assign d_rstall = tag_full_s | (d_rden & ~rgnt_d_s);
   assign c_wstall = c_wren & ~wgnt_c_s;
   assign d_wstall = d_wren & ~wgnt_d_s;

   assign c_oval       = c_oval_q;
   assign d_oval       = d_oval_q;
   assign c_odat       = c_odat_q;
   assign d_odat       = d_odat_q;
   assign o_err_orphan = err_q;

   // Master-side pass-through of the winning requester, zero when idle.
   always_comb begin
      m_rden = push_s;
      m_wren = wgnt_c_s | wgnt_d_s;
      if (rgnt_d_s) begin
         m_radd = d_radd;
      end else if (rgnt_c_s) begin
         m_radd = c_radd;
      end else begin
         m_radd = '0;
      end
      if (wgnt_d_s) begin
         m_wadd = d_wadd;
         m_idat = d_idat;
      end else if (wgnt_c_s) begin
         m_wadd = c_wadd;
         m_idat = c_idat;
      end else begin
         m_wadd = '0;
         m_idat = '0;
      end
   end

   // Next-state for the wait counters and the FIFO occupancy.
   always_comb begin
      rwait_d = '0;
      wwait_d = '0;
      cnt_d   = cnt_q;
      if (d_rden & ~rgnt_d_s) begin
         rwait_d = r_force_s ? rwait_q : (rwait_q + WAIT_ONE);
      end else begin
         rwait_d = '0;
      end
      if (d_wren & ~wgnt_d_s) begin
         wwait_d = w_force_s ? wwait_q : (wwait_q + WAIT_ONE);
      end else begin
         wwait_d = '0;
      end
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // Arbitration state and the in-order return tag FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rwait_q <= '0;
         wwait_q <= '0;
         tag_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         rwait_q <= rwait_d;
         wwait_q <= wwait_d;
         cnt_q   <= cnt_d;
         if (push_s) begin
            tag_q[wptr_q] <= rgnt_d_s;
            wptr_q        <= wptr_q + PTR_ONE;
         end
         if (pop_s) begin
            rptr_q <= rptr_q + PTR_ONE;
         end
      end
   end

   // Registered read-return routing and the sticky orphan-return flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_oval_q <= 1'b0;
         d_oval_q <= 1'b0;
         c_odat_q <= '0;
         d_odat_q <= '0;
         err_q    <= 1'b0;
      end else begin
         c_oval_q <= pop_s & ~head_s;
         d_oval_q <= pop_s & head_s;
         if (pop_s & ~head_s) begin
            c_odat_q <= m_odat;
         end
         if (pop_s & head_s) begin
            d_odat_q <= m_odat;
         end
         err_q <= err_q | (m_oval & tag_empty_s);
      end
   end

`ifdef PSUM_ARB_STAT_EN
   logic [31:0] rconf_q, wconf_q;
   assign o_stat_rconf = rconf_q;
   assign o_stat_wconf = wconf_q;

   // Count cycles in which both requesters contend for each channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rconf_q <= 32'd0;
         wconf_q <= 32'd0;
      end else begin
         rconf_q <= rconf_q + {31'd0, c_rden & d_rden};
         wconf_q <= wconf_q + {31'd0, c_wren & d_wren};
      end
   end
`endif

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Testbench for psum_mem_arbiter: table-driven grant vectors, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_psum_mem_arbiter;
   localparam int MW = 8;
   localparam int TD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] c_radd = '0, d_radd = '0, c_wadd = '0, d_wadd = '0;
   logic [31:0] c_idat = '0, d_idat = '0, m_odat = '0;
   logic c_rden = 1'b0, d_rden = 1'b0, c_wren = 1'b0, d_wren = 1'b0, m_oval = 1'b0;
   logic c_rstall, d_rstall, c_wstall, d_wstall, c_oval, d_oval;
   logic m_rden, m_wren, o_err_orphan;
   logic [31:0] c_odat, d_odat, m_radd, m_wadd, m_idat;
`ifdef PSUM_ARB_STAT_EN
   logic [31:0] o_stat_rconf, o_stat_wconf;
`endif

   psum_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .rst(rst),
      .c_radd(c_radd), .c_rden(c_rden), .c_rstall(c_rstall), .c_odat(c_odat), .c_oval(c_oval),
      .c_wadd(c_wadd), .c_wren(c_wren), .c_idat(c_idat), .c_wstall(c_wstall),
      .d_radd(d_radd), .d_rden(d_rden), .d_rstall(d_rstall), .d_odat(d_odat), .d_oval(d_oval),
      .d_wadd(d_wadd), .d_wren(d_wren), .d_idat(d_idat), .d_wstall(d_wstall),
      .m_radd(m_radd), .m_rden(m_rden), .m_odat(m_odat), .m_oval(m_oval),
      .m_wadd(m_wadd), .m_wren(m_wren), .m_idat(m_idat), .o_err_orphan(o_err_orphan)
`ifdef PSUM_ARB_STAT_EN
      , .o_stat_rconf(o_stat_rconf), .o_stat_wconf(o_stat_wconf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic cr; logic [31:0] ca; logic dr; logic [31:0] da;
      logic cw; logic [31:0] cwa; logic [31:0] cwd;
      logic dw; logic [31:0] dwa; logic [31:0] dwd;
      logic e_mrden; logic [31:0] e_mradd; logic e_cst; logic e_dst;
      logic e_mwren; logic [31:0] e_mwadd; logic [31:0] e_midat; logic e_cwst; logic e_dwst;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit   tagq[$];
   int   rwait_m, wwait_m;
   logic c_oval_e, d_oval_e, err_e;
   logic [31:0] c_odat_e, d_odat_e;
   bit   auto_bram;
   logic pend_v;
   logic [31:0] pend_a;

   // combinational observations from the latest step
   logic o_mrden, o_crst, o_dst, o_dwst;
   logic [31:0] o_mwadd, o_midat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic cr, input logic [31:0] ca, input logic dr, input logic [31:0] da,
                               input logic cw, input logic [31:0] cwa, input logic [31:0] cwd,
                               input logic dw, input logic [31:0] dwa, input logic [31:0] dwd);
      vec_t v;
      v.cr = cr; v.ca = ca; v.dr = dr; v.da = da;
      v.cw = cw; v.cwa = cwa; v.cwd = cwd; v.dw = dw; v.dwa = dwa; v.dwd = dwd;
      v.e_mrden = 1'b0; v.e_mradd = 32'h0; v.e_cst = 1'b0; v.e_dst = 1'b0;
      v.e_mwren = 1'b0; v.e_mwadd = 32'h0; v.e_midat = 32'h0; v.e_cwst = 1'b0; v.e_dwst = 1'b0;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vi, input logic mr, input logic [31:0] ma, input logic cs,
                               input logic ds, input logic mw, input logic [31:0] wa,
                               input logic [31:0] wd, input logic cws, input logic dws);
      vec_t v = vi;
      v.e_mrden = mr; v.e_mradd = ma; v.e_cst = cs; v.e_dst = ds;
      v.e_mwren = mw; v.e_mwadd = wa; v.e_midat = wd; v.e_cwst = cws; v.e_dwst = dws;
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      c_rden = 1'b0; d_rden = 1'b0; c_wren = 1'b0; d_wren = 1'b0; m_oval = 1'b0;
      c_radd = '0; d_radd = '0; c_wadd = '0; d_wadd = '0; c_idat = '0; d_idat = '0; m_odat = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      tagq.delete();
      rwait_m = 0; wwait_m = 0;
      c_oval_e = 1'b0; d_oval_e = 1'b0; err_e = 1'b0; c_odat_e = '0; d_odat_e = '0;
      pend_v = 1'b0; pend_a = '0;
      chk("rst_c_oval", 32'(c_oval), 32'h0);
      chk("rst_d_oval", 32'(d_oval), 32'h0);
      chk("rst_c_odat", c_odat, 32'h0);
      chk("rst_d_odat", d_odat, 32'h0);
      chk("rst_err", 32'(o_err_orphan), 32'h0);
      chk("rst_m_radd", m_radd, 32'h0);
      chk("rst_m_wren", 32'(m_wren), 32'h0);
   endtask

   // one clock cycle: drive, check combinational outputs, advance model, check registered outputs
   task automatic step(input vec_t v, input logic mv, input logic [31:0] md);
      logic mvx; logic [31:0] mdx, era, ewa, ewd;
      bit full, grc, grd, gwc, gwd, t;
      mvx = auto_bram ? pend_v : mv;
      mdx = auto_bram ? (pend_a + 32'h100) : md;
      c_rden = v.cr; c_radd = v.ca; d_rden = v.dr; d_radd = v.da;
      c_wren = v.cw; c_wadd = v.cwa; c_idat = v.cwd;
      d_wren = v.dw; d_wadd = v.dwa; d_idat = v.dwd;
      m_oval = mvx; m_odat = mdx;
      #1;
      full = (tagq.size() == TD);
      grd = v.dr && (!v.cr || rwait_m == MW) && !full;
      grc = v.cr && !grd && !full;
      gwd = v.dw && (!v.cw || wwait_m == MW);
      gwc = v.cw && !gwd;
      era = grd ? v.da : (grc ? v.ca : 32'h0);
      ewa = gwd ? v.dwa : (gwc ? v.cwa : 32'h0);
      ewd = gwd ? v.dwd : (gwc ? v.cwd : 32'h0);
      o_mrden = m_rden; o_crst = c_rstall; o_dst = d_rstall; o_dwst = d_wstall;
      o_mwadd = m_wadd; o_midat = m_idat;
      chk("m_rden", 32'(m_rden), 32'(grc || grd));
      chk("m_radd", m_radd, era);
      chk("c_rstall", 32'(c_rstall), 32'(full || (v.cr && !grc)));
      chk("d_rstall", 32'(d_rstall), 32'(full || (v.dr && !grd)));
      chk("m_wren", 32'(m_wren), 32'(gwc || gwd));
      chk("m_wadd", m_wadd, ewa);
      chk("m_idat", m_idat, ewd);
      chk("c_wstall", 32'(c_wstall), 32'(v.cw && !gwc));
      chk("d_wstall", 32'(d_wstall), 32'(v.dw && !gwd));
      c_oval_e = 1'b0; d_oval_e = 1'b0;
      if (mvx) begin
         if (tagq.size() > 0) begin
            t = tagq.pop_front();
            if (t) begin d_oval_e = 1'b1; d_odat_e = mdx; end
            else begin c_oval_e = 1'b1; c_odat_e = mdx; end
         end else begin
            err_e = 1'b1;
         end
      end
      if (grc || grd) tagq.push_back(grd);
      pend_v = grc || grd; pend_a = era;
      rwait_m = (v.dr && !grd) ? ((rwait_m < MW) ? rwait_m + 1 : MW) : 0;
      wwait_m = (v.dw && !gwd) ? ((wwait_m < MW) ? wwait_m + 1 : MW) : 0;
      @(posedge clk);
      #1;
      chk("c_oval", 32'(c_oval), 32'(c_oval_e));
      chk("d_oval", 32'(d_oval), 32'(d_oval_e));
      chk("c_odat", c_odat, c_odat_e);
      chk("d_odat", d_odat, d_odat_e);
      chk("o_err_orphan", 32'(o_err_orphan), 32'(err_e));
   endtask

   vec_t idle;
   vec_t tbl[7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndr, didx;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0] = ex(idle, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
      tbl[1] = ex(mk(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h10, 0, 0, 0, 32'h0, 32'h0, 0, 0);
      tbl[2] = ex(mk(0, 0, 1, 32'h44, 0, 0, 0, 0, 0, 0), 1, 32'h44, 0, 0, 0, 32'h0, 32'h0, 0, 0);
      tbl[3] = ex(mk(1, 32'h11, 1, 32'h45, 0, 0, 0, 0, 0, 0), 1, 32'h11, 0, 1, 0, 32'h0, 32'h0, 0, 0);
      tbl[4] = ex(mk(0, 0, 0, 0, 1, 32'h20, 32'hAAAA, 1, 32'h30, 32'h0), 0, 32'h0, 0, 0, 1, 32'h20, 32'hAAAA, 0, 1);
      tbl[5] = ex(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h31, 32'h5), 0, 32'h0, 0, 0, 1, 32'h31, 32'h5, 0, 0);
      tbl[6] = ex(mk(1, 32'h12, 1, 32'h46, 1, 32'h22, 32'h77, 1, 32'h32, 32'h88), 1, 32'h12, 0, 1, 1, 32'h22, 32'h77, 0, 1);

      auto_bram = 1'b0;
      do_reset();

      // table-driven single-cycle grant vectors, each from the reset state
      for (int i = 0; i < 7; i++) begin
         do_reset();
         step(tbl[i], 1'b0, 32'h0);
         chk($sformatf("tbl%0d_mrden", i), 32'(o_mrden), 32'(tbl[i].e_mrden));
         chk($sformatf("tbl%0d_dst", i), 32'(o_dst), 32'(tbl[i].e_dst));
         chk($sformatf("tbl%0d_mwadd", i), o_mwadd, tbl[i].e_mwadd);
         chk($sformatf("tbl%0d_midat", i), o_midat, tbl[i].e_midat);
         chk($sformatf("tbl%0d_dwst", i), 32'(o_dwst), 32'(tbl[i].e_dwst));
      end

      // core-only back-to-back reads, BRAM returns addr+0x100 one cycle later
      do_reset();
      auto_bram = 1'b1;
      step(mk(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
      step(mk(1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
      chk("t1_oval0", 32'(c_oval), 32'h1);
      chk("t1_odat0", c_odat, 32'h110);
      step(mk(1, 32'h12, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
      chk("t1_odat1", c_odat, 32'h111);
      step(idle, 1'b0, 32'h0);
      chk("t1_odat2", c_odat, 32'h112);
      chk("t1_doval", 32'(d_oval), 32'h0);
      step(idle, 1'b0, 32'h0);

      // continuous contention on the read channel: drain forced in on the 9th cycle
      do_reset();
      ndr = 0; didx = -1;
      for (int i = 0; i < 17; i++) begin
         step(mk(1, 32'h100 + 32'(i), 1, 32'h200 + 32'(i), 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
         if (!o_dst) begin ndr++; didx = i; end
      end
      chk("t2_drain_grants", 32'(ndr), 32'd1);
      chk("t2_drain_cycle", 32'(didx), 32'd8);
      step(idle, 1'b0, 32'h0);
      step(idle, 1'b0, 32'h0);
      auto_bram = 1'b0;

      // tag FIFO full: fifth read stalls until one return frees a slot
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(mk(1, 32'h40 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
         chk("t3_granted", 32'(o_mrden), 32'h1);
      end
      step(mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
      chk("t3_full_stall", 32'(o_crst), 32'h1);
      chk("t3_full_rden", 32'(o_mrden), 32'h0);
      step(mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 32'h55);
      chk("t3_pop_same_cycle_stall", 32'(o_crst), 32'h1);
      chk("t3_ret_data", c_odat, 32'h55);
      step(mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
      chk("t3_5th_granted", 32'(o_mrden), 32'h1);
      chk("t3_5th_nostall", 32'(o_crst), 32'h0);
      for (int i = 0; i < 4; i++) step(idle, 1'b1, 32'h60 + 32'(i));

      // simultaneous writes: core first, drain next once core drops
      do_reset();
      step(mk(0, 0, 0, 0, 1, 32'h20, 32'hAAAA, 1, 32'h30, 32'h0), 1'b0, 32'h0);
      chk("t4_wadd", o_mwadd, 32'h20);
      chk("t4_idat", o_midat, 32'hAAAA);
      chk("t4_dwstall", 32'(o_dwst), 32'h1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h30, 32'h0), 1'b0, 32'h0);
      chk("t4_drain_wadd", o_mwadd, 32'h30);
      chk("t4_drain_nostall", 32'(o_dwst), 32'h0);

      // orphan returns and reset with reads in flight
      do_reset();
      step(idle, 1'b1, 32'hDEAD);
      chk("t5_orphan", 32'(o_err_orphan), 32'h1);
      step(idle, 1'b0, 32'h0);
      step(idle, 1'b0, 32'h0);
      chk("t5_sticky", 32'(o_err_orphan), 32'h1);
      step(mk(1, 32'h70, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
      step(mk(0, 0, 1, 32'h71, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
      do_reset();
      step(idle, 1'b1, 32'hBEEF);
      chk("t5_late_orphan", 32'(o_err_orphan), 32'h1);
      chk("t5_late_no_oval", 32'(c_oval | d_oval), 32'h0);

`ifdef PSUM_ARB_STAT_EN
      do_reset();
      auto_bram = 1'b1;
      for (int i = 0; i < 10; i++) step(mk(1, 32'(i), 1, 32'h80 + 32'(i), 0, 0, 0, 0, 0, 0), 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 1, 32'(i), 32'h1, 1, 32'h90, 32'h2), 1'b0, 32'h0);
      chk("stat_rconf", o_stat_rconf, 32'd10);
      chk("stat_wconf", o_stat_wconf, 32'd3);
      auto_bram = 1'b0;
`endif

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(mk(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0), $urandom,
                 1'($urandom_range(0, 2) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom, $urandom),
              1'($urandom_range(0, 2) == 0), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/psum_mem_arbiter.md
Name: psum_mem_arbiter

Overview:
- Shares the two psum BRAM controller channels (read channel, write channel) between two requesters: requester 0 = accelerator core psum accumulate path; requester 1 = psum drain/readback engine (host result fetch).
- Sits between the core/drain logic and the psum bram_ctrl instances.
- Fixed-priority-to-core arbitration with an anti-starvation override for the drain requester.
- In-order read-return tag FIFO routes each BRAM read result back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 32, address width of all address ports.
- DATA_WIDTH, 32, psum data width.
- MAX_WAIT, 8, number of consecutive denied drain cycles before the drain requester is forced to win (per channel).
- TAG_DEPTH, 4, outstanding-read capacity of the return tag FIFO (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- c_radd  in  ADDR_WIDTH  core read address
- c_rden  in  1  core read request
- c_rstall  out  1  core read not granted this cycle; core holds c_radd/c_rden
- c_odat  out  DATA_WIDTH  core read data
- c_oval  out  1  core read data valid
- c_wadd  in  ADDR_WIDTH  core write address
- c_wren  in  1  core write request
- c_idat  in  DATA_WIDTH  core write data
- c_wstall  out  1  core write not granted
- d_radd, d_rden, d_rstall, d_odat, d_oval: drain read channel, same directions/widths/semantics as the core read channel
- d_wadd, d_wren, d_idat, d_wstall: drain write channel (psum clear), same as the core write channel
- m_radd  out  ADDR_WIDTH  to psum read bram_ctrl addr
- m_rden  out  1  to psum read bram_ctrl rden
- m_odat  in  DATA_WIDTH  from bram_ctrl odat
- m_oval  in  1  from bram_ctrl oval
- m_wadd  out  ADDR_WIDTH  to psum write bram_ctrl addr
- m_wren  out  1  to psum write bram_ctrl wren
- m_idat  out  DATA_WIDTH  to psum write bram_ctrl idat
- o_err_orphan  out  1  sticky: m_oval arrived with tag FIFO empty

Behaviour:
- The read and write channels arbitrate independently, each with its own wait counter (rwait, wwait; width clog2(MAX_WAIT+1); reset 0).
- Grant rule, per channel, per cycle, combinational:
  - Only one request active: that requester wins.
  - Both active: core wins unless the channel's wait counter == MAX_WAIT, in which case drain wins.
  - Neither active: no grant.
- Wait counter update, registered:
  - Drain denied while requesting: +1, saturating at MAX_WAIT.
  - Drain granted, or drain not requesting: cleared to 0.
- Stall outputs are combinational:
  - Requester requesting and not granted: stall=1.
  - Read channel only: tag FIFO full forces both c_rstall and d_rstall to 1, and m_rden=0.
- Master side is combinational pass-through of the winner:
  - m_rden=1 only on a granted read; m_wren=1 only on a granted write.
  - m_radd/m_wadd/m_idat = winner's signals, 0 when idle.
- Tag FIFO:
  - On a granted read, push tag (0=core, 1=drain).
  - On m_oval, pop the head tag and drive m_odat onto the matching side's odat with oval=1 for one cycle (registered: 1 cycle after m_oval). The other side's oval=0.
- Simultaneous push and pop: allowed, so count is unchanged. With a full FIFO and m_oval in the same cycle, the pop frees a slot next cycle (no same-cycle bypass).
- m_oval with FIFO empty: data discarded, no oval asserted, o_err_orphan set. It stays set until rst.
- Write data is never reordered. Read-after-write ordering across requesters is the requesters' responsibility.
- Reset values: c_oval=d_oval=0, c_odat=d_odat=0, o_err_orphan=0, FIFO empty, wait counters 0. m_* outputs are 0 whenever no request is present.
- Reset mid-operation clears all state. Any in-flight m_oval that arrives after reset falls under the FIFO-empty rule.

Optional Feature:
- Macro: PSUM_ARB_STAT_EN.
- Defined:
  - Adds outputs o_stat_rconf and o_stat_wconf, 32 bits each, reset 0.
  - Each counts cycles where both requesters requested its channel.
  - Wraps at 2^32; counting is suppressed while rst is high.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Core-only reads at 0x10, 0x11, 0x12 back-to-back; bram_ctrl model returns addr+0x100 after 1 cycle → c_oval on 3 consecutive cycles with 0x110, 0x111, 0x112; c_rstall=0; d_oval=0 throughout.
- Both read-request continuously with MAX_WAIT=8 → core granted 8 cycles, drain granted on the 9th, then core 8 more; d_rstall=1 on exactly the denied cycles; read data returns to the correct side in issue order.
- Hold m_oval low with TAG_DEPTH=4 and issue 5 core reads → 4 granted, 5th sees c_rstall=1 and m_rden=0. Then pulse m_oval once → the 5th read is granted on the following cycle.
- Simultaneous writes: core 0x20/0xAAAA, drain 0x30/0 → m_wadd=0x20, m_idat=0xAAAA, d_wstall=1. The next cycle drain writes 0x30 once the core drops c_wren.
- Pulse m_oval with no reads outstanding → o_err_orphan=1 and stays 1; c_oval=d_oval=0. Assert rst with 2 reads outstanding → FIFO clears; a late m_oval sets o_err_orphan again.
- With PSUM_ARB_STAT_EN: 10 cycles of dual read requests and 3 of dual write requests → o_stat_rconf=10, o_stat_wconf=3.
